control_unit: RTL and testbench



---
 rtl/control_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 33 +++
 rtl/control_unit.sv | 89 ++++++++
 tb/tb_control_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the MIPS-subset control unit: opcodes, funct codes,
// ALU op classes and the control bundles passed between decode stages.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Raw main-decoder result, before branch is qualified by the zero flag.
  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_source;
    logic    branch;
    logic    mem_write;
    logic    mem_to_reg;
    alu_op_e alu_op;
    logic    jump;
  } main_ctrl_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       pc_source;
    logic       alu_source;
    logic       reg_dst;
    logic       reg_write;
    logic       jump;
    logic [2:0] alu_control;
  } ctrl_out_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: selects the 3-bit ALU operation from the op
// class, consulting funct only for R-type instructions.
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:  alu_control = ALU_ADD;
      ALUOP_SUB:  alu_control = ALU_SUB;
      ALUOP_RSVD: alu_control = ALU_ADD;
      // funct is only looked at here, so an unknown funct on non-R-type
      // instructions can never propagate.
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control decoder for the single-cycle MIPS subset. Decodes Op/funct
// and registers all datapath controls, giving a one-clock decode stage.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memToReg,
  output logic       memWrite,
  output logic       pcSource,
  output logic       aluSource,
  output logic       regDst,
  output logic       regWrite,
  output logic       jump,
  output logic [2:0] aluControl
);

  main_ctrl_t main_ctrl;
  logic [2:0] alu_control_d;
  ctrl_out_t  ctrl_d;
  ctrl_out_t  ctrl_q;

  // Unknown opcodes decode to all-zero: no register, memory or PC side effects.
  always_comb begin
    main_ctrl = '{default: '0, alu_op: ALUOP_ADD};
    case (Op)
      OP_RTYPE: main_ctrl = '{reg_write: 1'b1, reg_dst: 1'b1, alu_source: 1'b0,
                              branch: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                              alu_op: ALUOP_FUNCT, jump: 1'b0};
      OP_LW:    main_ctrl = '{reg_write: 1'b1, reg_dst: 1'b0, alu_source: 1'b1,
                              branch: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b1,
                              alu_op: ALUOP_ADD, jump: 1'b0};
      OP_SW:    main_ctrl = '{reg_write: 1'b0, reg_dst: 1'b0, alu_source: 1'b1,
                              branch: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0,
                              alu_op: ALUOP_ADD, jump: 1'b0};
      OP_BEQ:   main_ctrl = '{reg_write: 1'b0, reg_dst: 1'b0, alu_source: 1'b0,
                              branch: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b0,
                              alu_op: ALUOP_SUB, jump: 1'b0};
      OP_ADDI:  main_ctrl = '{reg_write: 1'b1, reg_dst: 1'b0, alu_source: 1'b1,
                              branch: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                              alu_op: ALUOP_ADD, jump: 1'b0};
      OP_J:     main_ctrl = '{reg_write: 1'b0, reg_dst: 1'b0, alu_source: 1'b0,
                              branch: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                              alu_op: ALUOP_ADD, jump: 1'b1};
      default:  main_ctrl = '{default: '0, alu_op: ALUOP_ADD};
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (main_ctrl.alu_op),
    .funct       (funct),
    .alu_control (alu_control_d)
  );

  // Branch and zero come from the same edge, so the taken decision is
  // resolved before the register rather than after it.
  always_comb begin
    ctrl_d             = '0;
    ctrl_d.mem_to_reg  = main_ctrl.mem_to_reg;
    ctrl_d.mem_write   = main_ctrl.mem_write;
    ctrl_d.pc_source   = main_ctrl.branch & zero;
    ctrl_d.alu_source  = main_ctrl.alu_source;
    ctrl_d.reg_dst     = main_ctrl.reg_dst;
    ctrl_d.reg_write   = main_ctrl.reg_write;
    ctrl_d.jump        = main_ctrl.jump;
    ctrl_d.alu_control = alu_control_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign memToReg   = ctrl_q.mem_to_reg;
  assign memWrite   = ctrl_q.mem_write;
  assign pcSource   = ctrl_q.pc_source;
  assign aluSource  = ctrl_q.alu_source;
  assign regDst     = ctrl_q.reg_dst;
  assign regWrite   = ctrl_q.reg_write;
  assign jump       = ctrl_q.jump;
  assign aluControl = ctrl_q.alu_control;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// instruction streams compared against a table-driven reference model.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] funct;
  logic       zero;
  logic       memToReg, memWrite, pcSource, aluSource, regDst, regWrite, jump;
  logic [2:0] aluControl;

  int n_vec;
  int n_err;

  logic [9:0] exp_q[$];
  logic [8:0] main_tbl[logic [5:0]];
  logic [2:0] funct_tbl[logic [5:0]];

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .funct      (funct),
    .zero       (zero),
    .memToReg   (memToReg),
    .memWrite   (memWrite),
    .pcSource   (pcSource),
    .aluSource  (aluSource),
    .regDst     (regDst),
    .regWrite   (regWrite),
    .jump       (jump),
    .aluControl (aluControl)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: memToReg memWrite pcSource aluSource regDst regWrite jump aluControl
  function automatic logic [9:0] obs();
    return {memToReg, memWrite, pcSource, aluSource, regDst, regWrite, jump, aluControl};
  endfunction

  // ---------------- reference model ----------------
  // Rows: regWrite regDst aluSource branch memWrite memToReg aluOp[1:0] jump
  task automatic init_model();
    main_tbl[6'b000000] = 9'b1_1_0_0_0_0_10_0;
    main_tbl[6'b100011] = 9'b1_0_1_0_0_1_00_0;
    main_tbl[6'b101011] = 9'b0_0_1_0_1_0_00_0;
    main_tbl[6'b000100] = 9'b0_0_0_1_0_0_01_0;
    main_tbl[6'b001000] = 9'b1_0_1_0_0_0_00_0;
    main_tbl[6'b000010] = 9'b0_0_0_0_0_0_00_1;
    funct_tbl[6'b100000] = 3'b010;
    funct_tbl[6'b100010] = 3'b110;
    funct_tbl[6'b100100] = 3'b000;
    funct_tbl[6'b100101] = 3'b001;
    funct_tbl[6'b101010] = 3'b111;
  endtask

  function automatic logic [9:0] model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [8:0] row;
    logic [1:0] aop;
    logic [2:0] alu;
    row = main_tbl.exists(op) ? main_tbl[op] : 9'd0;
    aop = row[2:1];
    if (aop == 2'b01)      alu = 3'b110;
    else if (aop == 2'b10) alu = funct_tbl.exists(fn) ? funct_tbl[fn] : 3'b010;
    else                   alu = 3'b010;
    // memToReg memWrite pcSource aluSource regDst regWrite jump aluControl
    return {row[3], row[4], row[5] & z, row[6], row[7], row[8], row[0], alu};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(negedge clk);
    Op    = op;
    funct = fn;
    zero  = z;
    exp_q.push_back(model(op, fn, z));
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    Op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;
    #2;
    n_vec++;
    if (obs() !== 10'd0) begin
      n_err++;
      $display("FAIL reset_async got=%b want=%b", obs(), 10'd0);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== 10'd0) begin
      n_err++;
      $display("FAIL reset_held got=%b want=%b", obs(), 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5];
    logic [2:0] alus[5];
    logic [9:0] e;
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alus = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      drive(6'b000000, fns[i], 1'b0);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL rtype_%0d got=%b want=%b", i, obs(), e);
      end
      n_vec++;
      if ({regWrite, regDst, aluSource, aluControl} !== {3'b110, alus[i]}) begin
        n_err++;
        $display("FAIL rtype_fields_%0d got=%b want=%b", i,
                 {regWrite, regDst, aluSource, aluControl}, {3'b110, alus[i]});
      end
    end
  endtask

  task automatic test_mem();
    logic [9:0] e;
    drive(6'b100011, 6'bxxxxxx, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || obs() !== 10'b1001010_010) begin
      n_err++;
      $display("FAIL lw got=%b want=%b", obs(), e);
    end
    drive(6'b101011, 6'bxxxxxx, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || {memWrite, regWrite, aluSource} !== 3'b101) begin
      n_err++;
      $display("FAIL sw got=%b want=%b", obs(), e);
    end
  endtask

  task automatic test_beq();
    logic [9:0] e;
    drive(6'b000100, 6'b100101, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || pcSource !== 1'b0 || aluControl !== 3'b110) begin
      n_err++;
      $display("FAIL beq_not_taken got=%b want=%b", obs(), e);
    end
    drive(6'b000100, 6'b100101, 1'b1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || pcSource !== 1'b1 || regWrite !== 1'b0) begin
      n_err++;
      $display("FAIL beq_taken got=%b want=%b", obs(), e);
    end
    drive(6'b000000, 6'b100000, 1'b1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || pcSource !== 1'b0) begin
      n_err++;
      $display("FAIL zero_non_beq got=%b want=%b", obs(), e);
    end
  endtask

  task automatic test_addi_j();
    logic [9:0] e;
    drive(6'b001000, 6'bxxxxxx, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || {regWrite, aluSource, regDst, aluControl} !== 6'b110_010) begin
      n_err++;
      $display("FAIL addi got=%b want=%b", obs(), e);
    end
    drive(6'b000010, 6'bxxxxxx, 1'b1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || obs() !== 10'b0000001_010) begin
      n_err++;
      $display("FAIL jump got=%b want=%b", obs(), e);
    end
  endtask

  task automatic test_illegal();
    logic [9:0] e;
    drive(6'b111111, 6'b100010, 1'b1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e || {regWrite, memWrite, jump, pcSource} !== 4'b0000) begin
      n_err++;
      $display("FAIL illegal got=%b want=%b", obs(), e);
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] e;
    drive(6'b100011, 6'b000000, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL pre_reset got=%b want=%b", obs(), e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== 10'd0) begin
      n_err++;
      $display("FAIL mid_reset_async got=%b want=%b", obs(), 10'd0);
    end
    Op = 6'b000000;
    funct = 6'b101010;
    @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== 10'd0) begin
      n_err++;
      $display("FAIL mid_reset_discard got=%b want=%b", obs(), 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b000000, 6'b101010, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL post_reset got=%b want=%b", obs(), e);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    logic [9:0] e;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      drive(op, fn, 1'($urandom_range(0, 1)));
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL random_queue_empty at=%0d", i);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e) begin
          n_err++;
          $display("FAIL random_%0d op=%b fn=%b got=%b want=%b", i, op, fn, obs(), e);
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    init_model();
    test_reset();
    test_rtype();
    test_mem();
    test_beq();
    test_addi_j();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
